// File: rtl/tlk2711_tx_framer_if.sv
// Beat stream between the TX DMA read side and the TLK2711 transmit framer.
// The master drives beats, the slave (framer) returns ready.
interface tlk2711_tx_framer_if #(
  parameter int STREAM_DATA_WIDTH = 64
);
  logic                         i_s_tvalid;
  logic                         o_s_tready;
  logic [STREAM_DATA_WIDTH-1:0] i_s_tdata;
  logic                         i_s_tlast;

  modport master (output i_s_tvalid, output i_s_tdata, output i_s_tlast, input o_s_tready);
  modport slave  (input i_s_tvalid, input i_s_tdata, input i_s_tlast, output o_s_tready);
endinterface

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: 64-bit beats -> SOF, length, 16-bit payload words, EOF, K28.5 idle fill.
// Optional macro TLK2711_TX_CHECKSUM_EN inserts a 16-bit payload sum word before EOF.
module tlk2711_tx_framer #(
  parameter int STREAM_DATA_WIDTH = 64,
  parameter int DLEN_WIDTH        = 16,
  parameter int IDLE_GAP          = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tx_en,
  input  logic                  i_start,
  input  logic [DLEN_WIDTH-1:0] i_frame_len,
  tlk2711_tx_framer_if.slave    s_axis,
  output logic [15:0]           o_txd,
  output logic                  o_tkmsb,
  output logic                  o_tklsb,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underrun,
  output logic                  o_len_err
);
  localparam logic [15:0] K_IDLE = 16'hC5BC;
  localparam logic [15:0] K_SOF  = 16'h50FB;
  localparam logic [15:0] K_EOF  = 16'h50FD;
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(IDLE_GAP);
  localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0]      GAP_ZERO = GAP_W'(0);
  localparam logic [DLEN_WIDTH-1:0] LEN_ONE  = DLEN_WIDTH'(1);
  localparam logic [DLEN_WIDTH-1:0] LEN_ZERO = DLEN_WIDTH'(0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SOF = 3'd1, S_LEN = 3'd2, S_DATA = 3'd3,
    S_CSUM = 3'd4, S_EOF = 3'd5, S_GAP = 3'd6
  } state_e;

  function automatic logic [15:0] word_sel(input logic [STREAM_DATA_WIDTH-1:0] beat,
                                           input logic [1:0] idx);
    case (idx)
      2'd0:    word_sel = beat[15:0];
      2'd1:    word_sel = beat[31:16];
      2'd2:    word_sel = beat[47:32];
      default: word_sel = beat[63:48];
    endcase
  endfunction

  state_e                         state_q, state_d;
  logic [DLEN_WIDTH-1:0]          len_q, len_d, fetch_q, fetch_d, beats_q, beats_d;
  logic [STREAM_DATA_WIDTH-1:0]   buf_q, buf_d;
  logic                           buf_vld_q, buf_vld_d;
  logic [1:0]                     idx_q, idx_d;
  logic [GAP_W-1:0]               gap_q, gap_d;
  logic [15:0]                    txd_q, txd_d;
  logic                           tklsb_q, tklsb_d, ready_q, ready_d, busy_q, busy_d;
  logic                           done_q, done_d, underrun_q, underrun_d, len_err_q, len_err_d;
  logic                           accept_s;
  logic [15:0]                    word_s;
  logic [DLEN_WIDTH+1:0]          len_x4_s;
`ifdef TLK2711_TX_CHECKSUM_EN
  logic [15:0]                    sum_q, sum_d;
`endif

  assign accept_s = ready_q & s_axis.i_s_tvalid;
  assign word_s   = word_sel(buf_q, idx_q);
  assign len_x4_s = {len_q, 2'b00};

  // Next-state, beat buffer and registered-output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    fetch_d    = fetch_q;
    beats_d    = beats_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    txd_d      = K_IDLE;
    tklsb_d    = 1'b1;
    busy_d     = busy_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    len_err_d  = len_err_q;
`ifdef TLK2711_TX_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        gap_d = (gap_q != GAP_ZERO) ? (gap_q - GAP_ONE) : GAP_ZERO;
        if (i_start && i_tx_en && (gap_q == GAP_ZERO)) begin
          state_d    = S_SOF;
          len_d      = i_frame_len;
          fetch_d    = i_frame_len;
          beats_d    = i_frame_len;
          buf_vld_d  = 1'b0;
          idx_d      = 2'd0;
          busy_d     = 1'b1;
          underrun_d = 1'b0;
          len_err_d  = 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
          sum_d      = 16'h0000;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SOF: begin
        txd_d   = K_SOF;
        state_d = S_LEN;
      end
      S_LEN: begin
        txd_d   = len_x4_s[15:0];
        tklsb_d = 1'b0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (buf_vld_q) begin
          txd_d   = word_s;
          tklsb_d = 1'b0;
          idx_d   = idx_q + 2'd1;
`ifdef TLK2711_TX_CHECKSUM_EN
          sum_d   = sum_q + word_s;
`endif
          if (idx_q == 2'd3) begin
            buf_vld_d = 1'b0;
            beats_d   = beats_q - LEN_ONE;
`ifdef TLK2711_TX_CHECKSUM_EN
            state_d   = (beats_q == LEN_ONE) ? S_CSUM : S_DATA;
`else
            state_d   = (beats_q == LEN_ONE) ? S_EOF : S_DATA;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          // Starved: K28.5 holds the slot, word index stays put
          underrun_d = 1'b1;
        end
      end
      S_CSUM: begin
`ifdef TLK2711_TX_CHECKSUM_EN
        txd_d   = sum_q;
        tklsb_d = 1'b0;
`endif
        state_d = S_EOF;
      end
      S_EOF: begin
        txd_d   = K_EOF;
        done_d  = 1'b1;
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q <= GAP_ONE) begin
          gap_d   = GAP_ZERO;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load may coincide with word3 leaving, so it overrides the consume above
    if (accept_s) begin
      buf_d     = s_axis.i_s_tdata;
      buf_vld_d = 1'b1;
      idx_d     = 2'd0;
      fetch_d   = fetch_q - LEN_ONE;
      len_err_d = len_err_q | (s_axis.i_s_tlast != (fetch_q == LEN_ONE));
    end else begin
      fetch_d = fetch_d;
    end

    ready_d = (fetch_d != LEN_ZERO) && ((state_d == S_LEN) || (state_d == S_DATA)) &&
              (!buf_vld_d || (idx_d == 2'd3));
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= LEN_ZERO;
      fetch_q    <= LEN_ZERO;
      beats_q    <= LEN_ZERO;
      buf_q      <= {STREAM_DATA_WIDTH{1'b0}};
      buf_vld_q  <= 1'b0;
      idx_q      <= 2'd0;
      gap_q      <= GAP_LOAD;
      txd_q      <= K_IDLE;
      tklsb_q    <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      len_err_q  <= 1'b0;
`ifdef TLK2711_TX_CHECKSUM_EN
      sum_q      <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      fetch_q    <= fetch_d;
      beats_q    <= beats_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      txd_q      <= txd_d;
      tklsb_q    <= tklsb_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      len_err_q  <= len_err_d;
`ifdef TLK2711_TX_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign s_axis.o_s_tready = ready_q;
  assign o_txd             = txd_q;
  assign o_tkmsb           = 1'b0;
  assign o_tklsb           = tklsb_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_underrun        = underrun_q;
  assign o_len_err         = len_err_q;
endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Scoreboard bench for tlk2711_tx_framer: stimulus queues expected TX words, a negedge monitor pops and compares.
module tb_tlk2711_tx_framer;
  localparam int          IDLE_GAP = 4;
  localparam logic [15:0] K_IDLE   = 16'hC5BC;
  localparam logic [15:0] K_SOF    = 16'h50FB;
  localparam logic [15:0] K_EOF    = 16'h50FD;

  typedef struct packed {
    logic [15:0] txd;
    logic        k;
    logic        done;
    logic        chk_busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, tx_en, start;
  logic [15:0] frame_len;
  logic [15:0] txd;
  logic        tkmsb, tklsb, busy, done, underrun, len_err;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  bit          armed  = 1'b0;
  exp_t        exp_q[$];
  int          sof_cyc_q[$];
  logic [63:0] bt_data [0:3];
  bit          bt_last [0:3];
  int          bt_gap  [0:3];

  tlk2711_tx_framer_if #(.STREAM_DATA_WIDTH(64)) s_if ();

  tlk2711_tx_framer #(.STREAM_DATA_WIDTH(64), .DLEN_WIDTH(16), .IDLE_GAP(IDLE_GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tx_en     (tx_en),
    .i_start     (start),
    .i_frame_len (frame_len),
    .s_axis      (s_if),
    .o_txd       (txd),
    .o_tkmsb     (tkmsb),
    .o_tklsb     (tklsb),
    .o_busy      (busy),
    .o_done      (done),
    .o_underrun  (underrun),
    .o_len_err   (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] w, input logic k, input logic d, input logic cb);
    exp_t e;
    e.txd = w; e.k = k; e.done = d; e.chk_busy = cb;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every output word against the scoreboard once a frame starts
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        armed = 1'b0;
      end else begin
        if (!armed && (txd == K_SOF) && tklsb) begin
          check("sof_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            armed = 1'b1;
            if (sof_cyc_q.size() != 0) check("sof_latency", 32'(cyc), 32'(sof_cyc_q.pop_front()));
          end
        end
        if (armed) begin
          e = exp_q.pop_front();
          check("tx_word", 32'({tkmsb, tklsb, done, txd}), 32'({1'b0, e.k, e.done, e.txd}));
          if (e.chk_busy) check("busy_in_frame", 32'(busy), 32'd1);
          if (exp_q.size() == 0) armed = 1'b0;
        end else begin
          check("idle_word", 32'({tkmsb, tklsb, done, txd}), 32'({1'b0, 1'b1, 1'b0, K_IDLE}));
          if (exp_q.size() == 0) check("idle_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic send_beat(input int i);
    int g = 0;
    int t = 0;
    while (g < bt_gap[i] && t < 200) begin
      @(negedge clk);
      t++;
      if (s_if.o_s_tready) g++;
    end
    @(negedge clk);
    s_if.i_s_tvalid = 1'b1;
    s_if.i_s_tdata  = bt_data[i];
    s_if.i_s_tlast  = bt_last[i];
    t = 0;
    while (!s_if.o_s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("tready_seen", 32'(s_if.o_s_tready), 32'd1);
    @(posedge clk);
    #1;
    s_if.i_s_tvalid = 1'b0;
    s_if.i_s_tlast  = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit gap_start);
    logic [15:0] sum = 16'h0000;
    logic [15:0] w;
    logic [63:0] beat;
    int t = 0;
    push_exp(K_SOF, 1'b1, 1'b0, 1'b1);
    push_exp(16'(n * 4), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < bt_gap[i]; g++) push_exp(K_IDLE, 1'b1, 1'b0, 1'b1);
      beat = bt_data[i];
      for (int j = 0; j < 4; j++) begin
        w = beat[16*j +: 16];
        sum = sum + w;
        push_exp(w, 1'b0, 1'b0, 1'b1);
      end
    end
`ifdef TLK2711_TX_CHECKSUM_EN
    push_exp(sum, 1'b0, 1'b0, 1'b1);
`endif
    push_exp(K_EOF, 1'b1, 1'b1, 1'b1);
    for (int g = 0; g < IDLE_GAP; g++) push_exp(K_IDLE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    frame_len = 16'(n);
    sof_cyc_q.push_back(cyc + 2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) send_beat(i);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done), 32'd1);
    if (gap_start) begin
      start = 1'b1;
      frame_len = 16'd1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (IDLE_GAP + 2) @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1; tx_en = 1'b1; start = 1'b0; frame_len = 16'd0;
    s_if.i_s_tvalid = 1'b0; s_if.i_s_tdata = 64'd0; s_if.i_s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    check("reset_len_err", 32'(len_err), 32'd0);
    check("reset_tready", 32'(s_if.o_s_tready), 32'd0);

    // Single beat frame; a start during the idle gap must be dropped
    bt_data[0] = 64'h0004_0003_0002_0001; bt_last[0] = 1'b1; bt_gap[0] = 0;
    run_frame(1, 1'b1);
    check("t2_underrun", 32'(underrun), 32'd0);
    check("t2_len_err", 32'(len_err), 32'd0);

    // Two beats with the stream starved for three word slots
    bt_data[0] = 64'h4444_3333_2222_1111; bt_last[0] = 1'b0; bt_gap[0] = 0;
    bt_data[1] = 64'h8888_7777_6666_5555; bt_last[1] = 1'b1; bt_gap[1] = 3;
    run_frame(2, 1'b0);
    check("t3_underrun", 32'(underrun), 32'd1);
    check("t3_len_err", 32'(len_err), 32'd0);

    // Start with transmit disabled is ignored and keeps sticky flags
    tx_en = 1'b0;
    @(negedge clk); start = 1'b1; frame_len = 16'd1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    check("txen_busy", 32'(busy), 32'd0);
    check("txen_underrun_sticky", 32'(underrun), 32'd1);
    tx_en = 1'b1;

    // tlast on the first of two beats: frame ends by count, length error flagged
    bt_data[0] = 64'hDEAD_BEEF_CAFE_F00D; bt_last[0] = 1'b1; bt_gap[0] = 0;
    bt_data[1] = 64'h0123_4567_89AB_CDEF; bt_last[1] = 1'b0; bt_gap[1] = 0;
    run_frame(2, 1'b0);
    check("t4_underrun_cleared", 32'(underrun), 32'd0);
    check("t4_len_err", 32'(len_err), 32'd1);

    // Reset while payload is being sent
    mon_en = 1'b0;
    @(negedge clk); start = 1'b1; frame_len = 16'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    s_if.i_s_tvalid = 1'b1; s_if.i_s_tdata = 64'h0004_0003_0002_0001; s_if.i_s_tlast = 1'b1;
    t = 0;
    while (!s_if.o_s_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("rst_tready_seen", 32'(s_if.o_s_tready), 32'd1);
    @(posedge clk);
    #1;
    s_if.i_s_tvalid = 1'b0; s_if.i_s_tlast = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_txd", 32'({tklsb, txd}), 32'({1'b1, K_IDLE}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_len_err", 32'(len_err), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    mon_en = 1'b1;

    // Recovery frame after mid-frame reset
    bt_data[0] = 64'h0F00_00F0_000F_F000; bt_last[0] = 1'b1; bt_gap[0] = 0;
    run_frame(1, 1'b0);
    check("t5_len_err", 32'(len_err), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("sof_queue_drained", 32'(sof_cyc_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
